// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its queue.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; the head is read straight from the
// storage registers so decode sees a registered value.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output fetch_entry_t     head_o
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_entry_t     mem_q [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(QDEPTH));
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The credit rule upstream means a push never meets a full queue.
  assert property (@(posedge clk) disable iff (rst) !(do_push && full && !do_pop));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: credit-limited request issue, in-order response tracking with
// stale-response dropping after redirects, and a small registered queue towards decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  localparam int unsigned     CNT_W     = $clog2(QDEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_LIM = (CNT_W + 1)'(QDEPTH);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] queue_count;
  logic [CNT_W:0]   credits_used;
  logic [XLEN-1:0]  redirect_target;
  logic             req_fire, rsp_stale;
  logic             q_push, q_pop, q_empty;
  fetch_entry_t     q_entry, q_head;
  logic             unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // In-flight requests plus queued entries may never exceed the queue depth.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, queue_count};
  assign imem_req_valid = !rst && (state_q == RUN) && !halt && !redirect_valid &&
                          (credits_used < DEPTH_LIM);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_stale = (drop_cnt_q != '0);
  assign q_push    = imem_rsp_valid && !rsp_stale;
  assign q_entry   = '{pc: rsp_pc_q, instr: imem_rsp_data};

  assign if_valid = !q_empty && !redirect_valid;
  assign q_pop    = if_valid && if_ready;
  assign if_pc    = q_head.pc;
  assign if_instr = q_head.instr;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    unique case (state_q)
      RUN:     if (halt) state_d = HALT;
      HALT:    if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase

    unique case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (req_fire) begin
      fetch_pc_d = pc_next(fetch_pc_q);
    end

    if (imem_rsp_valid) begin
      if (rsp_stale) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end else begin
        rsp_pc_d = pc_next(rsp_pc_q);
      end
    end

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  instr_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .entry_i (q_entry),
    .pop_i   (q_pop),
    .count_o (queue_count),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

endmodule
